// File: rtl/ptltx_pkg.sv
//------------------------------------------------------------------------------
// ptltx_pkg: shared FSM state type and counter-width helper for ptltx_multi_chan
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ptltx_pkg;

    typedef enum logic [0:0] {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ptltx_chan.sv
//------------------------------------------------------------------------------
// ptltx_chan: one toggle-encoded pulse channel (edge detect, hold guard, delay)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ptltx_chan
    import ptltx_pkg::*;
#(
    parameter int DELAY = 2,
    parameter int HOLD  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic active,
    input  logic viol_clr,
    output logic q,
    output logic viol
);

    localparam int GW = cnt_width(HOLD);

    logic             a_d;
    logic [GW-1:0]    guard;
    logic [DELAY-1:0] dl;
    logic [DELAY-1:0] dl_next;
    logic             pulse;
    logic             free;
    logic             accept;
    logic             violate;

    assign pulse   = active & (a ^ a_d);
    assign free    = (guard == '0);
    assign accept  = pulse & free;
    assign violate = pulse & ~free;

    generate
        if (DELAY == 1) begin : g_dl_one
            assign dl_next = accept;
        end else begin : g_dl_many
            assign dl_next = {dl[DELAY-2:0], accept};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d   <= 1'b0;
            guard <= '0;
            dl    <= '0;
            q     <= 1'b0;
            viol  <= 1'b0;
        end else begin
            a_d <= a;
            // A dropped pulse does not reload the guard; it keeps counting down.
            if (accept)
                guard <= GW'(HOLD - 1);
            else if (!free)
                guard <= guard - GW'(1);
            dl   <= dl_next;
            q    <= q ^ dl[DELAY-1];
            viol <= (viol & ~viol_clr) | violate;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ptltx_multi_chan.sv
//------------------------------------------------------------------------------
// ptltx_multi_chan: multi-channel PTL transmitter with startup blanking window
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ptltx_multi_chan
    import ptltx_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DELAY       = 2,
    parameter int HOLD        = 4,
    parameter int INIT_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] a,
    input  logic                viol_clr,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] viol,
    output logic                ready
);

    localparam int CW = cnt_width(INIT_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          active;

    assign active = (state == ST_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == CW'(INIT_CYCLES - 1)) begin
                        state <= ST_ACTIVE;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ACTIVE: ready <= 1'b1;
                default: begin
                    state <= ST_INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            ptltx_chan #(
                .DELAY (DELAY),
                .HOLD  (HOLD)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .a        (a[i]),
                .active   (active),
                .viol_clr (viol_clr),
                .q        (q[i]),
                .viol     (viol[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ptltx_multi_chan.sv
//------------------------------------------------------------------------------
// tb_ptltx_multi_chan: directed and randomized checks against an edge-count model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ptltx_multi_chan;

    localparam int CH    = 4;
    localparam int DLY   = 2;
    localparam int HLD   = 4;
    localparam int INITC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] a = '0;
    logic          viol_clr = 1'b0;
    logic [CH-1:0] q;
    logic [CH-1:0] viol;
    logic          ready;

    always #5 clk = ~clk;

    ptltx_multi_chan #(
        .CHANNELS    (CH),
        .DELAY       (DLY),
        .HOLD        (HLD),
        .INIT_CYCLES (INITC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .viol_clr (viol_clr),
        .q        (q),
        .viol     (viol),
        .ready    (ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: edges counted since reset release, per-channel timing rules.
    int            n;
    int            last_acc [CH];
    bit            acc_valid[CH];
    int            due      [CH][$];
    logic [CH-1:0] a_prev;
    logic [CH-1:0] q_m;
    logic [CH-1:0] viol_m;
    logic          ready_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    task automatic model_reset();
        n       = 0;
        a_prev  = '0;
        q_m     = '0;
        viol_m  = '0;
        ready_m = 1'b0;
        for (int i = 0; i < CH; i++) begin
            acc_valid[i] = 1'b0;
            last_acc[i]  = 0;
            due[i].delete();
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] vset;
        n++;
        vset = '0;
        for (int i = 0; i < CH; i++) begin
            if (due[i].size() > 0 && due[i][0] == n) begin
                void'(due[i].pop_front());
                q_m[i] = ~q_m[i];
            end
            if (n > INITC && (a[i] ^ a_prev[i])) begin
                if (!acc_valid[i] || (n - last_acc[i]) >= HLD) begin
                    acc_valid[i] = 1'b1;
                    last_acc[i]  = n;
                    due[i].push_back(n + DLY);
                end else begin
                    vset[i] = 1'b1;
                end
            end
        end
        a_prev  = a;
        viol_m  = (viol_clr ? '0 : viol_m) | vset;
        ready_m = (n >= INITC);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".q"},     32'(q),     32'(q_m));
        chk({tag, ".viol"},  32'(viol),  32'(viol_m));
        chk({tag, ".ready"}, 32'(ready), 32'(ready_m));
    endtask

    // Called at a falling edge; applies toggles, clocks once, checks at next falling edge.
    task automatic step(input logic [CH-1:0] tog, input logic clr, input string tag);
        a        = a ^ tog;
        viol_clr = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        repeat (2) @(negedge clk);
        viol_clr = 1'b0;
        rst_n    = 1'b1;
    endtask

    logic [CH-1:0] tog;
    logic          clr;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("por");
        rst_n = 1'b1;

        // Directed scenario; edge k is the k-th rising edge after release.
        for (int k = 1; k <= 60; k++) begin
            tog = '0;
            clr = 1'b0;
            case (k)
                3, 5, 60:   tog = 4'b0001;
                20:         tog = 4'b0010;
                30, 32, 34: tog = 4'b0100;
                40:         tog = 4'b0100;
                41: begin   tog = 4'b0100; clr = 1'b1; end
                42:         clr = 1'b1;
                50:         tog = 4'b1111;
                default: ;
            endcase
            step(tog, clr, "dir");
            if (k == 8)  chk("blank_q", 32'(q), 32'h0);
            if (k == 22) chk("lat_q1", 32'(q[1]), 32'h1);
            if (k == 32) chk("hold_viol2", 32'(viol[2]), 32'h1);
            if (k == 41) chk("race_viol2", 32'(viol[2]), 32'h1);
            if (k == 42) chk("clr_viol2", 32'(viol[2]), 32'h0);
        end
        async_reset("midrst");
        chk("midrst_q", 32'(q), 32'h0);

        // Randomized rounds, each ending with a reset while pulses may be in flight.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 300; k++) begin
                tog = CH'($urandom) & CH'($urandom);
                clr = ($urandom_range(7) == 0);
                step(tog, clr, "rnd");
            end
            async_reset("rndrst");
        end
        for (int k = 0; k < 20; k++) step('0, 1'b0, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ptltx_multi_chan.md
Name: ptltx_multi_chan

Overview:
- Parametrised, clocked successor to the single-channel PTL transmitter cell model.
- Carries CHANNELS independent RSFQ pulse channels. Each channel uses toggle encoding: every edge on an input is one pulse.
- Each channel has a programmable transmit delay, a startup blanking window (begin-time equivalent) and a per-channel minimum-spacing (hold) check that drops violating pulses and flags them.
- Sits between RSFQ logic-cell models and PTL receiver models in link-level simulations.

Parameters:
- CHANNELS, 4: number of independent pulse channels (>=1).
- DELAY, 2: cycles from pulse detection to output toggle (>=1).
- HOLD, 4: minimum spacing in cycles between accepted pulses on one channel (>=1; 1 disables the check).
- INIT_CYCLES, 8: cycles after reset release during which input pulses are ignored (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  CHANNELS  toggle-encoded input pulses, one bit per channel, synchronous to clk.
- viol_clr  input  1  clears all sticky violation flags.
- q  output  CHANNELS  toggle-encoded output pulses.
- viol  output  CHANNELS  sticky per-channel hold-violation flag.
- ready  output  1  high once the startup window has elapsed.

Behaviour:
- Reset, asynchronous on rst_n low:
  - q=0, viol=0, ready=0.
  - Delay pipelines and guard counters cleared.
  - Edge-detect register a_d=0.
  - FSM enters INIT with its counter at 0.
- FSM:
  - INIT: counter increments each cycle. a_d <= a every cycle, so input edges in INIT are discarded. After INIT_CYCLES cycles, go to ACTIVE.
  - ACTIVE: ready=1. Stays here until reset.
  - Reset mid-operation: in-flight pulses are lost, q returns to 0, INIT restarts.
- Pulse detection, ACTIVE only: p[i] = a[i] ^ a_d[i], sampled at each rising edge; a_d <= a.
- Acceptance:
  - A pulse is accepted if guard[i]==0. Acceptance loads guard[i]=HOLD-1.
  - Otherwise guard[i] decrements toward 0 each cycle.
  - A pulse detected while guard[i]!=0 is a violation: it is dropped, viol[i] is set, and guard[i] is not reloaded.
  - With HOLD=1 the guard never blocks.
- Latency: an accepted pulse detected at edge t toggles q[i] at edge t+DELAY. The delay line is a DELAY-deep shift register per channel. Back-to-back accepted pulses (possible only when HOLD=1) each produce their own toggle.
- Ordering: pulses are delivered in detection order. No merging occurs: two accepted pulses never collapse into a single toggle.
- viol_clr:
  - Synchronous. Clears all viol bits on the next edge.
  - A new violation on the same edge wins (bit stays set).
  - No effect on guards or pipelines.
- Channels are fully independent. Simultaneous pulses on different channels are each handled normally.
- Pulses already in the delay line when the block is in INIT: impossible by construction, because pipelines are cleared at reset.

Decomposition:
- Shared package ptltx_pkg holds:
  - FSM state enum (ST_INIT, ST_ACTIVE).
  - Width helper function for counters: clog2-based, minimum 1.
- One sub-module, ptltx_chan: edge detect, guard counter, delay line and q/viol for a single channel.
  - Its inputs from the top level are the active enable and viol_clr.
  - The top level instantiates it CHANNELS times under a generate loop and owns the INIT FSM.

Test Plan:
- Startup blanking: release reset at cycle 0 and toggle a[0] at cycles 3 and 5 -> q stays 0, viol=0, ready rises after cycle 8.
- Nominal latency: in ACTIVE, toggle a[1] at cycle 20 -> q[1] toggles exactly at cycle 22; other q bits unchanged.
- Hold violation: toggle a[2] at cycles 30 and 32 (HOLD=4) -> a single q[2] toggle at 32 and viol[2]=1. A further toggle at 34 is accepted (guard expired), giving a q[2] toggle at 36.
- Clear vs set race: with viol[2]=1, assert viol_clr on the same edge as a new a[2] violation -> viol[2] remains 1. viol_clr alone on the next cycle -> viol[2]=0.
- All channels simultaneous: toggle a[3:0] together at cycle 50 -> q[3:0] all toggle at cycle 52, no viol set.
- Reset mid-flight: toggle a[0] at cycle 60 and pull rst_n low at cycle 61 -> q=0 immediately, no toggle at 62, ready=0, INIT restarts.
